// File: rtl/manchester_frame_decoder.sv
// Manchester frame decoder: arm, capture FRAME_BITS half-bit pairs, hold frame until ack.
// Define MANCHESTER_ERRCHK_EN to flag half-pair violations on err and abort the frame.
module manchester_frame_decoder #(
  parameter int FRAME_BITS = 45,
  parameter bit POLARITY   = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                              sqwv,
  input  logic                              rst_n,
  input  logic                              half_tick,
  input  logic                              half_bit,
  input  logic                              arm,
  input  logic                              ack,
  output logic [FRAME_BITS-1:0]             decoded,
  output logic                              done,
  output logic                              busy,
  output logic                              err,
  output logic [$clog2(FRAME_BITS+1)-1:0]   bit_count
);
  localparam int CW = $clog2(FRAME_BITS+1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS-1);

  typedef enum logic [1:0] {IDLE, HALF0, HALF1, DONE} state_t;

  state_t          state;
  logic            prev_tick;
  logic            first_half;
  logic            ev;
  logic            dbit;
  logic [CW-1:0]   idx;
  logic [FRAME_BITS-1:0] mask;

  // Either edge of half_tick is a sample event, seen one cycle after it happens.
  assign ev = half_tick ^ prev_tick;

  always_comb begin
    dbit = first_half ^ POLARITY;
    idx  = MSB_FIRST ? (LAST - bit_count) : bit_count;
    mask = FRAME_BITS'(1) << idx;
  end

`ifdef MANCHESTER_ERRCHK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge sqwv or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      decoded    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      bit_count  <= '0;
      prev_tick  <= 1'b0;
      first_half <= 1'b0;
`ifdef MANCHESTER_ERRCHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      prev_tick <= half_tick;
      case (state)
        IDLE: if (arm) begin
          state     <= HALF0;
          busy      <= 1'b1;
          decoded   <= '0;
          bit_count <= '0;
`ifdef MANCHESTER_ERRCHK_EN
          err_q     <= 1'b0;
`endif
        end
        HALF0: if (ev) begin
          first_half <= half_bit;
          state      <= HALF1;
        end
        HALF1: if (ev) begin
`ifdef MANCHESTER_ERRCHK_EN
          // A valid bit always has a mid-bit transition; equal halves abort the frame.
          if (half_bit == first_half) begin
            err_q <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else
`endif
          begin
            // Each index is written once per frame after the arm-time clear, so OR suffices.
            decoded   <= decoded | (dbit ? mask : '0);
            bit_count <= bit_count + 1'b1;
            if (bit_count == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= HALF0;
            end
          end
        end
        DONE: if (ack) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_manchester_frame_decoder.sv
// Randomized bench for manchester_frame_decoder: 8-bit MSB/LSB-first and 45-bit inverted-polarity instances.
module tb_manchester_frame_decoder;
  logic sqwv = 1'b0;
  logic rst_n, half_tick, half_bit, arm8, ack8, arm45, ack45;

  logic [7:0]  dec_m, dec_l;
  logic        done_m, busy_m, err_m, done_l, busy_l, err_l;
  logic [3:0]  bc_m, bc_l;
  logic [44:0] dec45;
  logic        done45, busy45, err45;
  logic [5:0]  bc45;

  logic        sel45;
  logic [63:0] bc_obs;
  logic        dn_obs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 sqwv = ~sqwv;

  manchester_frame_decoder #(.FRAME_BITS(8), .POLARITY(1'b0), .MSB_FIRST(1'b1)) u8m (
    .sqwv(sqwv), .rst_n(rst_n), .half_tick(half_tick), .half_bit(half_bit),
    .arm(arm8), .ack(ack8), .decoded(dec_m), .done(done_m), .busy(busy_m),
    .err(err_m), .bit_count(bc_m));

  manchester_frame_decoder #(.FRAME_BITS(8), .POLARITY(1'b0), .MSB_FIRST(1'b0)) u8l (
    .sqwv(sqwv), .rst_n(rst_n), .half_tick(half_tick), .half_bit(half_bit),
    .arm(arm8), .ack(ack8), .decoded(dec_l), .done(done_l), .busy(busy_l),
    .err(err_l), .bit_count(bc_l));

  manchester_frame_decoder #(.FRAME_BITS(45), .POLARITY(1'b1), .MSB_FIRST(1'b1)) u45 (
    .sqwv(sqwv), .rst_n(rst_n), .half_tick(half_tick), .half_bit(half_bit),
    .arm(arm45), .ack(ack45), .decoded(dec45), .done(done45), .busy(busy45),
    .err(err45), .bit_count(bc45));

  always_comb begin
    bc_obs = sel45 ? 64'(bc45) : 64'(bc_m);
    dn_obs = sel45 ? done45 : done_m;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected frame: v is the bit sequence sent MSB of v first; k-th bit on the wire
  // lands at n-1-k (MSB-first) or k (LSB-first).
  function automatic logic [63:0] model_frame(input int n, input bit msb, input logic [63:0] v);
    bit q[$];
    logic [63:0] f;
    f = '0;
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    foreach (q[k]) f[msb ? (n - 1 - k) : k] = q[k];
    return f;
  endfunction

  // Called at a negedge; returns at a negedge after the event has been consumed.
  task automatic send_half(input logic lvl, input int gap);
    half_bit  = lvl;
    half_tick = ~half_tick;
    repeat (gap) @(negedge sqwv);
  endtask

  task automatic send_frame(input int n, input logic [63:0] v, input logic pol);
    for (int i = 0; i < n; i++) begin
      logic fh;
      fh = v[n-1-i] ^ pol;
      send_half(fh, int'($urandom_range(1, 3)));
      send_half(~fh, (i == n - 1) ? 1 : int'($urandom_range(1, 3)));
      if (i < n - 1) begin
        chk("bit_count", bc_obs, 64'(i + 1));
        chk("done_early", 64'(dn_obs), 64'd0);
      end
    end
  endtask

  initial begin
    logic [63:0] v, v45, held;
    rst_n = 1'b0; half_tick = 1'b0; half_bit = 1'b0;
    arm8 = 1'b0; ack8 = 1'b0; arm45 = 1'b0; ack45 = 1'b0; sel45 = 1'b0;
    repeat (3) @(negedge sqwv);
    chk("rst_decoded", 64'(dec_m), 64'd0);
    chk("rst_done", 64'(done_m), 64'd0);
    chk("rst_busy", 64'(busy_m), 64'd0);
    chk("rst_err", 64'(err_m), 64'd0);
    chk("rst_bc", 64'(bc_m), 64'd0);
    chk("rst_dec45", 64'(dec45), 64'd0);
    rst_n = 1'b1;
    @(negedge sqwv);

    // 0xA5 on both 8-bit instances
    arm8 = 1'b1; @(negedge sqwv); arm8 = 1'b0;
    chk("busy_after_arm", 64'(busy_m), 64'd1);
    chk("bc_after_arm", 64'(bc_m), 64'd0);
    send_frame(8, 64'hA5, 1'b0);
    chk("a5_msb", 64'(dec_m), 64'hA5);
    chk("a5_lsb", 64'(dec_l), 64'hA5);
    chk("a5_done", 64'(done_m), 64'd1);
    chk("a5_bc", 64'(bc_m), 64'd8);
    chk("a5_busy", 64'(busy_m), 64'd0);
    chk("a5_err", 64'(err_m), 64'd0);
    ack8 = 1'b1; @(negedge sqwv); ack8 = 1'b0;
    chk("ack_done", 64'(done_m), 64'd0);
    chk("ack_retain", 64'(dec_m), 64'hA5);

    // 0x01 -> reversed on the LSB-first instance
    arm8 = 1'b1; @(negedge sqwv); arm8 = 1'b0;
    send_frame(8, 64'h01, 1'b0);
    chk("x01_msb", 64'(dec_m), 64'h01);
    chk("x01_lsb", 64'(dec_l), 64'h80);
    chk("x01_done_l", 64'(done_l), 64'd1);
    ack8 = 1'b1; @(negedge sqwv); ack8 = 1'b0;

    // Random frames; odd iterations arm on an event cycle and keep arm/ack high while busy
    for (int it = 0; it < 6; it++) begin
      v = 64'($urandom_range(0, 255));
      if (it % 2 == 1) begin
        arm8 = 1'b1; ack8 = 1'b1;
        half_bit = 1'($urandom_range(0, 1)); half_tick = ~half_tick;
        @(negedge sqwv);
        chk("arm_evt_busy", 64'(busy_m), 64'd1);
        chk("arm_evt_bc", 64'(bc_m), 64'd0);
      end else begin
        arm8 = 1'b1; @(negedge sqwv); arm8 = 1'b0;
      end
      send_frame(8, v, 1'b0);
      chk("rnd_msb", 64'(dec_m), model_frame(8, 1'b1, v));
      chk("rnd_lsb", 64'(dec_l), model_frame(8, 1'b0, v));
      chk("rnd_done", 64'(done_l), 64'd1);
      arm8 = 1'b0; ack8 = 1'b1; @(negedge sqwv); ack8 = 1'b0;
      chk("rnd_ack", 64'(done_m), 64'd0);
    end

`ifdef MANCHESTER_ERRCHK_EN
    // Third bit sent as 1,1 aborts with err
    arm8 = 1'b1; @(negedge sqwv); arm8 = 1'b0;
    send_half(1'b1, 1); send_half(1'b0, 1);
    send_half(1'b0, 1); send_half(1'b1, 1);
    send_half(1'b1, 1); send_half(1'b1, 1);
    chk("viol_err", 64'(err_m), 64'd1);
    chk("viol_err_l", 64'(err_l), 64'd1);
    chk("viol_busy", 64'(busy_m), 64'd0);
    chk("viol_bc", 64'(bc_m), 64'd2);
    chk("viol_done", 64'(done_m), 64'd0);
    chk("viol_dec", 64'(dec_m), 64'h80);
    for (int k = 0; k < 4; k++) send_half(1'($urandom_range(0, 1)), 2);
    chk("viol_idle_bc", 64'(bc_m), 64'd2);
    chk("viol_hold_err", 64'(err_m), 64'd1);
    arm8 = 1'b1; @(negedge sqwv); arm8 = 1'b0;
    chk("rearm_err", 64'(err_m), 64'd0);
    chk("rearm_busy", 64'(busy_m), 64'd1);
    v = 64'($urandom_range(0, 255));
    send_frame(8, v, 1'b0);
    chk("rearm_frame", 64'(dec_m), model_frame(8, 1'b1, v));
    ack8 = 1'b1; @(negedge sqwv); ack8 = 1'b0;
`else
    // Without checking, a 1,1 pair decodes from the first half only
    arm8 = 1'b1; @(negedge sqwv); arm8 = 1'b0;
    v = 64'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        send_half(1'b1, int'($urandom_range(1, 3)));
        send_half(1'b1, int'($urandom_range(1, 3)));
      end else begin
        send_half(v[7-i], int'($urandom_range(1, 3)));
        send_half(~v[7-i], int'($urandom_range(1, 3)));
      end
    end
    chk("nochk_dec", 64'(dec_m), model_frame(8, 1'b1, v | 64'h20));
    chk("nochk_done", 64'(done_m), 64'd1);
    chk("nochk_err", 64'(err_m), 64'd0);
    ack8 = 1'b1; @(negedge sqwv); ack8 = 1'b0;
`endif

    // 45-bit frame, inverted polarity, long hold in DONE
    sel45 = 1'b1;
    arm45 = 1'b1; @(negedge sqwv); arm45 = 1'b0;
    v45 = {32'($urandom), 32'($urandom)} & ((64'd1 << 45) - 1);
    send_frame(45, v45, 1'b1);
    chk("f45_dec", 64'(dec45), model_frame(45, 1'b1, v45));
    chk("f45_done", 64'(done45), 64'd1);
    chk("f45_bc", 64'(bc45), 64'd45);
    chk("f45_busy", 64'(busy45), 64'd0);
    chk("f45_err", 64'(err45), 64'd0);
    chk("f8_idle_bc", 64'(bc_m), 64'd8);
    for (int c = 0; c < 100; c++) begin
      if (c % 10 == 5) begin
        half_bit = 1'($urandom_range(0, 1)); half_tick = ~half_tick;
      end
      @(negedge sqwv);
    end
    chk("hold_dec", 64'(dec45), model_frame(45, 1'b1, v45));
    chk("hold_done", 64'(done45), 64'd1);
    chk("hold_bc", 64'(bc45), 64'd45);
    ack45 = 1'b1; @(negedge sqwv); ack45 = 1'b0;
    chk("f45_ack", 64'(done45), 64'd0);
    chk("f45_retain", 64'(dec45), model_frame(45, 1'b1, v45));

    // Reset after 20 of 45 bits
    arm45 = 1'b1; @(negedge sqwv); arm45 = 1'b0;
    v = 64'($urandom_range(0, 20'hFFFFF)) | 64'h80000;
    send_frame(20, v, 1'b1);
    chk("part_bc", 64'(bc45), 64'd20);
    chk("part_busy", 64'(busy45), 64'd1);
    chk("part_nonzero", 64'(dec45 != '0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dec", 64'(dec45), 64'd0);
    chk("arst_bc", 64'(bc45), 64'd0);
    chk("arst_busy", 64'(busy45), 64'd0);
    chk("arst_done", 64'(done45), 64'd0);
    chk("arst_err", 64'(err45), 64'd0);
    chk("arst_dec8", 64'(dec_m), 64'd0);
    @(negedge sqwv);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) send_half(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    chk("noarm_bc", 64'(bc45), 64'd0);
    chk("noarm_busy", 64'(busy45), 64'd0);
    chk("noarm_dec", 64'(dec45), 64'd0);
    chk("noarm_done", 64'(done45), 64'd0);
    arm45 = 1'b1; @(negedge sqwv); arm45 = 1'b0;
    v45 = {32'($urandom), 32'($urandom)} & ((64'd1 << 45) - 1);
    send_frame(45, v45, 1'b1);
    chk("post_rst_dec", 64'(dec45), model_frame(45, 1'b1, v45));
    held = 64'(dec45);
    ack45 = 1'b1; @(negedge sqwv); ack45 = 1'b0;
    chk("post_rst_ack", 64'(done45), 64'd0);
    chk("post_rst_retain", 64'(dec45), model_frame(45, 1'b1, v45));
    chk("post_rst_held", held, model_frame(45, 1'b1, v45));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/manchester_frame_decoder.md
MANCHESTER_FRAME_DECODER -- requirements
Module: manchester_frame_decoder

Interface
REQ-001 Parameter FRAME_BITS, default 45, sets the decoded frame length in bits; legal range is 2..64.
REQ-002 Parameter POLARITY, default 0: 0 means data bit = first half-bit; 1 means data bit = inverted first half-bit.
REQ-003 Parameter MSB_FIRST, default 1: 1 means the first bit lands in decoded[FRAME_BITS-1]; 0 means it lands in decoded[0].
REQ-004 sqwv  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 half_tick  input  1  half-bit strobe; every level change (either direction) marks one half-bit sample event.
REQ-007 half_bit  input  1  demodulated line level, sampled on each half-bit event.
REQ-008 arm  input  1  request to start capturing a frame; honoured only in IDLE.
REQ-009 ack  input  1  consumer acknowledge of a completed frame; honoured only in DONE.
REQ-010 decoded  output  FRAME_BITS  captured frame.
REQ-011 done  output  1  frame complete and held until ack.
REQ-012 busy  output  1  high in HALF0 and HALF1.
REQ-013 err  output  1  Manchester violation flag; see Configuration.
REQ-014 bit_count  output  $clog2(FRAME_BITS+1)  number of bits stored in the current frame.

Function
REQ-015 A registered copy of half_tick, prev_tick, shall update every cycle; event = (half_tick != prev_tick), giving a one-cycle detection latency.
REQ-016 FSM states shall be IDLE, HALF0, HALF1 and DONE.
REQ-017 IDLE + arm -> HALF0; on this transition bit_count and decoded shall clear to 0, err shall clear, and a coincident event shall be ignored.
REQ-018 HALF0 + event -> HALF1; half_bit shall be latched as first_half.
REQ-019 HALF1 + event -> store the data bit at index bit_count (MSB_FIRST=0) or FRAME_BITS-1-bit_count (MSB_FIRST=1), and increment bit_count.
REQ-020 After the store in REQ-019, the FSM shall go to DONE if bit_count reaches FRAME_BITS, otherwise to HALF0.
REQ-021 done shall rise on the same edge that stores the final bit, so the full frame is on decoded the same cycle done is high.
REQ-022 In DONE, decoded and bit_count shall hold and events shall be ignored.
REQ-023 DONE + ack -> IDLE; done shall clear on that edge and decoded shall retain its value.
REQ-024 arm in HALF0, HALF1 or DONE shall be ignored; ack outside DONE shall be ignored.
REQ-025 Events in IDLE shall be ignored; at most one event is processed per cycle.

Reset
REQ-026 rst_n low shall immediately force state=IDLE, decoded=0, done=0, busy=0, err=0, bit_count=0, prev_tick=0 and first_half=0.
REQ-027 Reset mid-frame shall discard all partial data; after release the block shall need a new arm before capturing.

Configuration
REQ-028 Macro MANCHESTER_ERRCHK_EN shall control violation checking.
REQ-029 With MANCHESTER_ERRCHK_EN defined, a HALF1 event where half_bit equals first_half shall set err=1, store nothing, leave bit_count unchanged, and return to IDLE.
REQ-030 With MANCHESTER_ERRCHK_EN defined, err shall stay high until the next accepted arm or reset.
REQ-031 Without MANCHESTER_ERRCHK_EN, err shall be tied to 0 and the bit shall be taken from first_half only (per POLARITY), with no check of the second half.

Verification
REQ-032 FRAME_BITS=8, MSB_FIRST=1, POLARITY=0; arm, then 16 half-bit events encoding 0xA5 -> decoded=8'hA5, done=1 on the final store edge, bit_count=8, busy=0.
REQ-033 Same as REQ-032 with MSB_FIRST=0 -> decoded=8'hA5 bit-reversed = 8'hA5 (palindrome check); repeat with 0x01 -> decoded=8'h80.
REQ-034 MANCHESTER_ERRCHK_EN defined; third bit sent as half-pair 1,1 -> err=1, state IDLE, bit_count=2, done=0; next arm clears err to 0.
REQ-035 FRAME_BITS=45; full frame captured; ack held low for 100 cycles with 10 further events -> decoded unchanged, done stays 1; one-cycle ack -> done=0 next edge.
REQ-036 rst_n pulsed low after 20 bits of a 45-bit frame -> all outputs 0 asynchronously; events without arm -> no change.
REQ-037 arm asserted in the same cycle as the first event -> that event ignored; arm asserted while busy -> no effect on bit_count.
